// File: rtl/queue_drain.sv
// Single-byte drain for the 8-entry byte queue: rate-limited dequeue requests,
// a one-byte valid/ready output stage, a delivery counter and a sticky timeout flag.
module queue_drain #(
    parameter int INTERVAL = 10,
    parameter int TIMEOUT  = 8
) (
    input  logic       clock_10KHZ,
    input  logic       reset,
    input  logic [3:0] len_in,
    input  logic [7:0] data_in,
    output logic       dequeue_out,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] consumed_count,
    output logic       timeout_err
);

    localparam logic [7:0] INTERVAL_C = 8'(INTERVAL);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, PRESENT, HOLDOFF} state_t;

    state_t     r_state;
    logic [7:0] r_interval;
    logic [7:0] r_wait;
    logic [3:0] r_len_snap;
    logic       r_dequeue;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic [7:0] r_count;
    logic       r_timeout_err;

    logic w_interval_done;
    logic w_len_nonzero;
    logic w_len_drop;

    assign w_interval_done = (r_interval == INTERVAL_C);
    assign w_len_nonzero   = (len_in != 4'd0);
    // Only a fall below the snapshot completes a request; a concurrent enqueue
    // can push len_in above the snapshot without satisfying it.
    assign w_len_drop      = (len_in < r_len_snap);

    always_ff @(posedge clock_10KHZ or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_interval    <= 8'd0;
            r_wait        <= 8'd0;
            r_len_snap    <= 4'd0;
            r_dequeue     <= 1'b0;
            r_out_data    <= 8'h00;
            r_out_valid   <= 1'b0;
            r_count       <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (!w_interval_done) begin
                r_interval <= r_interval + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_len_nonzero && w_interval_done) begin
                        r_len_snap <= len_in;
                        r_dequeue  <= 1'b1;
                        r_wait     <= 8'd0;
                        r_interval <= 8'd0;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (w_len_drop) begin
                        r_out_data  <= data_in;
                        r_out_valid <= 1'b1;
                        r_dequeue   <= 1'b0;
                        r_state     <= PRESENT;
                    end else if (r_wait == WAIT_LAST) begin
                        r_dequeue     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= HOLDOFF;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                PRESENT: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_count     <= r_count + 8'd1;
                        r_state     <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dequeue_out    = r_dequeue;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign consumed_count = r_count;
    assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_queue_drain.sv
// Scoreboard bench for queue_drain: a byte-queue model feeds the DUT, popped bytes
// are expected downstream in order, and a negedge monitor checks every transfer.
`timescale 1ns/1ps
module tb_queue_drain;
    localparam int INTERVAL = 10;
    localparam int TIMEOUT  = 8;

    logic       clock_10KHZ = 1'b0;
    logic       reset       = 1'b1;
    logic [3:0] len_in      = 4'd0;
    logic [7:0] data_in     = 8'h00;
    logic       out_ready   = 1'b0;
    logic       dequeue_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] consumed_count;
    logic       timeout_err;

    queue_drain #(.INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT)) dut (
        .clock_10KHZ    (clock_10KHZ),
        .reset          (reset),
        .len_in         (len_in),
        .data_in        (data_in),
        .dequeue_out    (dequeue_out),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .consumed_count (consumed_count),
        .timeout_err    (timeout_err)
    );

    always #5 clock_10KHZ = ~clock_10KHZ;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] sb[$];
    int         model_count = 0;
    logic [7:0] exp_byte;

    int cyc = 0, last_rise = 0, hi_len = 0, last_hi_len = 0, pop_wait = 0;
    bit have_rise = 0, prev_deq = 0, stuck = 0, popped = 0, rand_ready = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer is due on the next rising edge when valid and ready are both high here.
    always @(negedge clock_10KHZ) begin
        if (reset) begin
            sb.delete();
            model_count = 0;
        end else begin
            check("consumed_count", int'(consumed_count), model_count);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", int'(out_data), -1);
                end else begin
                    exp_byte = sb.pop_front();
                    check("out_data", int'(out_data), int'(exp_byte));
                    $display("xfer: out_data=%02h expected=%02h count->%0d",
                             out_data, exp_byte, (model_count + 1) % 256);
                end
                model_count = (model_count + 1) % 256;
            end
        end
    end

    task automatic enq(input logic [7:0] b);
        q.push_back(b);
        len_in = 4'(q.size());
    endtask

    // One clock: track request timing, then let the queue model react.
    task automatic step();
        @(posedge clock_10KHZ);
        #1;
        cyc++;
        if (dequeue_out && !prev_deq) begin
            check("req_needs_data", int'(len_in != 4'd0), 1);
            if (have_rise) check("req_spacing", int'((cyc - last_rise) >= INTERVAL), 1);
            last_rise = cyc;
            have_rise = 1;
            hi_len    = 0;
        end
        if (dequeue_out) hi_len++;
        if (!dequeue_out && prev_deq) begin
            last_hi_len = hi_len;
            check("req_high_bound", int'(hi_len <= TIMEOUT), 1);
        end
        prev_deq = dequeue_out;
        if (!stuck) begin
            if (!dequeue_out) begin
                popped   = 0;
                pop_wait = int'($urandom_range(0, 3));
            end else if (!popped) begin
                if (pop_wait == 0) begin
                    if (q.size() > 0) begin
                        data_in = q.pop_front();
                        sb.push_back(data_in);
                    end
                    popped = 1;
                end else begin
                    pop_wait--;
                end
            end
        end
        len_in = 4'(q.size());
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_deq(input bit level, input int bound, input string name);
        int i = 0;
        while (dequeue_out != level && i < bound) begin
            step();
            i++;
        end
        check(name, int'(dequeue_out), int'(level));
    endtask

    task automatic wait_valid(input int bound, input string name);
        int i = 0;
        while (!out_valid && i < bound) begin
            step();
            i++;
        end
        check(name, int'(out_valid), 1);
    endtask

    task automatic drain(input int bound, input string name);
        int i = 0;
        while ((q.size() != 0 || dequeue_out || out_valid) && i < bound) begin
            step();
            i++;
        end
        check(name, int'(q.size() != 0 || dequeue_out || out_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dequeue"}, int'(dequeue_out), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_count"}, int'(consumed_count), 0);
        check({tag, "_timeout"}, int'(timeout_err), 0);
    endtask

    task automatic clear_model();
        q.delete();
        len_in    = 4'd0;
        have_rise = 0;
        prev_deq  = 0;
        popped    = 0;
        stuck     = 0;
    endtask

    initial begin
        int quiet;
        clear_model();
        repeat (3) step();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Empty queue: nothing is ever requested.
        quiet = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (dequeue_out || out_valid || timeout_err || consumed_count != 8'd0) quiet = 1;
        end
        check("len0_quiet", quiet, 0);
        check_reset_outputs("len0");

        // Three bytes drained in order with downstream always ready.
        out_ready = 1'b1;
        enq(8'hA1); enq(8'hB2); enq(8'hC3);
        drain(200, "three_drain");
        step();
        check("three_count", int'(consumed_count), 3);
        check("three_timeout", int'(timeout_err), 0);

        // Backpressure: byte held while out_ready is low, another byte waiting in the queue.
        out_ready = 1'b0;
        enq(8'h5A); enq(8'h6B);
        wait_valid(60, "bp_capture");
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_valid_held", int'(out_valid), 1);
            check("bp_data_stable", int'(out_data), 8'h5A);
            check("bp_no_request", int'(dequeue_out), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_valid_fall", int'(out_valid), 0);
        check("bp_count", int'(consumed_count), 4);
        out_ready = 1'b1;
        drain(100, "bp_drain");

        // Queue ignores the request: timeout after exactly TIMEOUT high cycles.
        stuck = 1;
        for (int i = 0; i < 5; i++) enq(8'(8'h70 + i));
        wait_deq(1'b1, 60, "to_req_start");
        wait_deq(1'b0, 30, "to_req_end");
        check("to_high_cycles", last_hi_len, TIMEOUT);
        check("to_err_set", int'(timeout_err), 1);
        check("to_no_valid", int'(out_valid), 0);
        wait_deq(1'b1, 60, "to_next_req");
        check("to_err_sticky", int'(timeout_err), 1);
        check("to_no_valid2", int'(out_valid), 0);
        wait_deq(1'b0, 30, "to_next_end");
        stuck = 0;
        drain(300, "to_drain");
        check("to_err_after_ok", int'(timeout_err), 1);
        check("to_count", int'(consumed_count), 10);

        // Enqueue during a request does not complete it; only len below the snapshot does.
        stuck = 1;
        enq(8'h11); enq(8'h22); enq(8'h33); enq(8'h44);
        wait_deq(1'b1, 60, "enq_req_start");
        enq(8'h55);
        step();
        check("enq_len5_req", int'(dequeue_out), 1);
        check("enq_len5_novalid", int'(out_valid), 0);
        data_in = q.pop_front();
        len_in  = 4'(q.size());
        step();
        check("enq_len4_req", int'(dequeue_out), 1);
        check("enq_len4_novalid", int'(out_valid), 0);
        data_in = q.pop_front();
        sb.push_back(data_in);
        len_in  = 4'(q.size());
        step();
        check("enq_len3_valid", int'(out_valid), 1);
        check("enq_len3_deq_low", int'(dequeue_out), 0);
        check("enq_len3_data", int'(out_data), 8'h22);
        stuck = 0;
        drain(300, "enq_drain");
        check("enq_count", int'(consumed_count), 14);

        // Randomized traffic: random enqueues between requests, random ready.
        rand_ready = 1;
        for (int i = 0; i < 500; i++) begin
            if (!dequeue_out && q.size() < 8 && $urandom_range(0, 3) == 0) enq(8'($urandom));
            step();
        end
        drain(600, "rand_drain");
        rand_ready = 0;
        out_ready  = 1'b1;

        // Reset while presenting byte number eight.
        reset = 1'b1;
        clear_model();
        repeat (2) step();
        reset = 1'b0;
        check_reset_outputs("rst1");
        for (int i = 0; i < 7; i++) enq(8'(8'hC0 + i));
        drain(300, "seven_drain");
        step();
        check("seven_count", int'(consumed_count), 7);
        out_ready = 1'b0;
        enq(8'hEE);
        wait_valid(60, "mid_capture");
        check("mid_valid", int'(out_valid), 1);
        check("mid_count", int'(consumed_count), 7);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        clear_model();
        repeat (2) step();
        reset = 1'b0;
        check_reset_outputs("post_rst");
        out_ready = 1'b1;
        enq(8'h3C);
        drain(100, "resume_drain");
        step();
        check("resume_count", int'(consumed_count), 1);
        check("resume_timeout", int'(timeout_err), 0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
